// File: rtl/irq_controller.sv
// Interrupt controller/sequencer: latches request edges, picks the lowest-index
// eligible line and runs a PUSH -> JUMP -> SERVICE redirect at an instruction boundary.
module irq_controller #(
  parameter int unsigned         NUM_IRQ    = 4,
  parameter int unsigned         WIDTH      = 16,
  parameter logic [WIDTH-1:0]    VEC_BASE   = 'h0008,
  parameter int unsigned         VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ien,
  input  logic               boundary,
  input  logic               stack_full,
  input  logic [WIDTH-1:0]   pc,
  input  logic               reti,
  output logic               hold,
  output logic               stack_push,
  output logic               jmp_en,
  output logic [WIDTH-1:0]   jmp_addr,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               active,
  output logic [NUM_IRQ-1:0] pending,
  output logic               lost
);

  localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH,
    S_JUMP,
    S_SERVICE
  } state_t;

  state_t             r_state;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic               r_lost;
  logic [IW-1:0]      r_idx;
  logic               r_hold;
  logic               r_push;
  logic               r_jmp_en;
  logic [WIDTH-1:0]   r_jmp_addr;
  logic [NUM_IRQ-1:0] r_ack;
  logic               r_active;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_onehot;
  logic [NUM_IRQ-1:0] w_clr;
  logic [IW-1:0]      w_win;
  logic [WIDTH-1:0]   w_vec;
  logic               w_unused_pc;

  // pc is captured by the return stack itself; nothing here consumes it.
  assign w_unused_pc = ^pc;

  assign w_rise   = irq & ~r_prev;
  assign w_elig   = ien ? (r_pending & ~irq_mask) : '0;
  assign w_onehot = NUM_IRQ'(1) << r_idx;
  assign w_vec    = VEC_BASE + WIDTH'(VEC_STRIDE * 32'(r_idx));
  // Clear lands on the edge entering JUMP so pending already reads 0 there.
  assign w_clr    = (r_state == S_PUSH) ? w_onehot : '0;

  always_comb begin
    w_win = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (w_elig[i-1]) w_win = IW'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prev     <= irq;
      r_pending  <= '0;
      r_lost     <= 1'b0;
      r_idx      <= '0;
      r_hold     <= 1'b0;
      r_push     <= 1'b0;
      r_jmp_en   <= 1'b0;
      r_jmp_addr <= '0;
      r_ack      <= '0;
      r_active   <= 1'b0;
    end else begin
      r_prev    <= irq;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      // An edge on the line being cleared re-arms it rather than counting as lost.
      if (|(w_rise & r_pending & ~w_clr)) r_lost <= 1'b1;
      r_hold     <= 1'b0;
      r_push     <= 1'b0;
      r_jmp_en   <= 1'b0;
      r_jmp_addr <= '0;
      r_ack      <= '0;
      case (r_state)
        S_IDLE: begin
          if ((|w_elig) && boundary && !stack_full) begin
            r_state <= S_PUSH;
            r_idx   <= w_win;
            r_hold  <= 1'b1;
            r_push  <= 1'b1;
          end
        end
        S_PUSH: begin
          r_state    <= S_JUMP;
          r_jmp_en   <= 1'b1;
          r_jmp_addr <= w_vec;
          r_ack      <= w_onehot;
        end
        S_JUMP: begin
          r_state  <= S_SERVICE;
          r_active <= 1'b1;
        end
        S_SERVICE: begin
          if (reti) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hold       = r_hold;
  assign stack_push = r_push;
  assign jmp_en     = r_jmp_en;
  assign jmp_addr   = r_jmp_addr;
  assign irq_ack    = r_ack;
  assign active     = r_active;
  assign pending    = r_pending;
  assign lost       = r_lost;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a cycle table for one dispatch plus
// hand sequences for priority, blocking, edge/lost corners, reset and vector wrap.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        ien;
  logic        boundary;
  logic        stack_full;
  logic [15:0] pc;
  logic        reti;

  logic        hold, stack_push, jmp_en, active, lost;
  logic [15:0] jmp_addr;
  logic [3:0]  irq_ack, pending;

  logic        w2_hold, w2_push, w2_jmp_en, w2_active, w2_lost;
  logic [15:0] w2_jmp_addr;
  logic [3:0]  w2_ack, w2_pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_controller #(.NUM_IRQ(4), .WIDTH(16), .VEC_BASE(16'h0008), .VEC_STRIDE(4)) u_dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask), .ien(ien),
    .boundary(boundary), .stack_full(stack_full), .pc(pc), .reti(reti),
    .hold(hold), .stack_push(stack_push), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .irq_ack(irq_ack), .active(active), .pending(pending), .lost(lost)
  );

  irq_controller #(.NUM_IRQ(4), .WIDTH(16), .VEC_BASE(16'hFFFC), .VEC_STRIDE(4)) u_wrap (
    .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask), .ien(ien),
    .boundary(boundary), .stack_full(stack_full), .pc(pc), .reti(reti),
    .hold(w2_hold), .stack_push(w2_push), .jmp_en(w2_jmp_en), .jmp_addr(w2_jmp_addr),
    .irq_ack(w2_ack), .active(w2_active), .pending(w2_pending), .lost(w2_lost)
  );

  typedef struct {
    logic [3:0]  irq;
    logic        reti;
    logic        hold;
    logic        push;
    logic        jmp;
    logic [15:0] addr;
    logic [3:0]  ack;
    logic        act;
    logic [3:0]  pend;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_hold, input logic e_push,
                         input logic e_jmp, input logic [15:0] e_addr, input logic [3:0] e_ack,
                         input logic e_act, input logic [3:0] e_pend);
    chk({tag, ".hold"},     32'(hold),       32'(e_hold));
    chk({tag, ".push"},     32'(stack_push), 32'(e_push));
    chk({tag, ".jmp_en"},   32'(jmp_en),     32'(e_jmp));
    chk({tag, ".jmp_addr"}, 32'(jmp_addr),   32'(e_addr));
    chk({tag, ".irq_ack"},  32'(irq_ack),    32'(e_ack));
    chk({tag, ".active"},   32'(active),     32'(e_act));
    chk({tag, ".pending"},  32'(pending),    32'(e_pend));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic blocked_case(input int which, input string tag);
    irq_mask = 4'b0000; ien = 1'b1; boundary = 1'b1; stack_full = 1'b0;
    case (which)
      0: irq_mask = 4'b0001;
      1: ien = 1'b0;
      2: boundary = 1'b0;
      default: stack_full = 1'b1;
    endcase
    irq = 4'b0001; tick();
    irq = 4'b0000; tick();
    tick();
    chk_out({tag, ".blocked"}, 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0001);
    irq_mask = 4'b0000; ien = 1'b1; boundary = 1'b1; stack_full = 1'b0;
    tick();
    chk_out({tag, ".push"}, 1, 1, 0, 16'h0000, 4'b0000, 0, 4'b0001);
    tick();
    chk_out({tag, ".jump"}, 0, 0, 1, 16'h0008, 4'b0001, 0, 4'b0000);
    tick();
    chk({tag, ".active"}, 32'(active), 32'd1);
    reti = 1'b1; tick(); reti = 1'b0;
    chk({tag, ".reti"}, 32'(active), 32'd0);
  endtask

  initial begin
    rst = 1'b1; irq = '0; irq_mask = '0; ien = 1'b1; boundary = 1'b1;
    stack_full = 1'b0; pc = 16'h0005; reti = 1'b0;

    tbl[0] = '{4'b0100, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0100};
    tbl[1] = '{4'b0100, 0, 1, 1, 0, 16'h0000, 4'b0000, 0, 4'b0100};
    tbl[2] = '{4'b0000, 0, 0, 0, 1, 16'h0010, 4'b0100, 0, 4'b0000};
    tbl[3] = '{4'b0000, 0, 0, 0, 0, 16'h0000, 4'b0000, 1, 4'b0000};
    tbl[4] = '{4'b0000, 1, 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000};
    tbl[5] = '{4'b0000, 1, 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000};

    tick();
    chk_out("reset", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);
    chk("reset.lost", 32'(lost), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      irq  = tbl[i].irq;
      reti = tbl[i].reti;
      tick();
      chk_out($sformatf("single[%0d]", i), tbl[i].hold, tbl[i].push, tbl[i].jmp,
              tbl[i].addr, tbl[i].ack, tbl[i].act, tbl[i].pend);
    end
    reti = 1'b0;
    chk("single.lost", 32'(lost), 32'd0);

    // Priority: lines 1 and 3 together, line 1 first, line 3 after reti.
    irq = 4'b1010; tick();
    chk_out("prio.latch", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b1010);
    irq = 4'b0000; tick();
    chk_out("prio.push1", 1, 1, 0, 16'h0000, 4'b0000, 0, 4'b1010);
    tick();
    chk_out("prio.jump1", 0, 0, 1, 16'h000C, 4'b0010, 0, 4'b1000);
    chk("wrap.jmp_en", 32'(w2_jmp_en), 32'd1);
    chk("wrap.jmp_addr", 32'(w2_jmp_addr), 32'h0000);
    tick();
    chk_out("prio.svc1", 0, 0, 0, 16'h0000, 4'b0000, 1, 4'b1000);
    tick();
    chk_out("prio.nonest", 0, 0, 0, 16'h0000, 4'b0000, 1, 4'b1000);
    reti = 1'b1; tick(); reti = 1'b0;
    chk_out("prio.reti1", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b1000);
    tick();
    chk_out("prio.push3", 1, 1, 0, 16'h0000, 4'b0000, 0, 4'b1000);
    tick();
    chk_out("prio.jump3", 0, 0, 1, 16'h0014, 4'b1000, 0, 4'b0000);
    tick();
    reti = 1'b1; tick(); reti = 1'b0;
    chk_out("prio.reti3", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);

    blocked_case(0, "blk_mask");
    blocked_case(1, "blk_ien");
    blocked_case(2, "blk_boundary");
    blocked_case(3, "blk_stackfull");

    // Line held high through reset must not latch.
    irq = 4'b0001; rst = 1'b1; tick(); rst = 1'b0;
    tick();
    chk("held.pending", 32'(pending), 32'h0);
    tick();
    chk_out("held.idle", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);
    irq = 4'b0000; tick();

    // Second edge on an already-pending line sets lost.
    irq_mask = 4'b0001;
    irq = 4'b0001; tick(); irq = 4'b0000; tick();
    chk("lost.first", 32'(lost), 32'd0);
    irq = 4'b0001; tick(); irq = 4'b0000;
    chk("lost.second", 32'(lost), 32'd1);
    chk("lost.pending", 32'(pending), 32'h1);
    tick();
    chk("lost.sticky", 32'(lost), 32'd1);
    do_reset();
    #1;
    chk("lost.reset", 32'(lost), 32'd0);
    chk("lost.reset_pend", 32'(pending), 32'h0);
    irq_mask = 4'b0000;

    // Edge on line 0 sampled together with its own clear: set wins.
    irq = 4'b0001; tick(); irq = 4'b0000; tick();
    chk("jumpedge.push", 32'(hold), 32'd1);
    irq = 4'b0001; tick();
    chk_out("jumpedge.jump", 0, 0, 1, 16'h0008, 4'b0001, 0, 4'b0001);
    irq = 4'b0000; irq_mask = 4'b0001; tick();
    chk_out("jumpedge.svc", 0, 0, 0, 16'h0000, 4'b0000, 1, 4'b0001);
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    chk_out("jumpedge.masked", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0001);
    do_reset();
    irq_mask = 4'b0000;
    tick();

    // Reset in PUSH, then reset in SERVICE.
    irq = 4'b0100; tick(); irq = 4'b0000; tick();
    chk("rstpush.hold", 32'(hold), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_out("rstpush", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);
    tick();
    chk_out("rstpush.after", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);
    irq = 4'b0100; tick(); irq = 4'b0000; tick(); tick(); tick();
    irq = 4'b1000; tick(); irq = 4'b0000;
    chk_out("rstsvc.before", 0, 0, 0, 16'h0000, 4'b0000, 1, 4'b1000);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_out("rstsvc", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);
    chk("rstsvc.lost", 32'(lost), 32'd0);
    tick();
    chk_out("rstsvc.after", 0, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller and sequencer for the accumulator processor. It latches rising edges on external request lines and picks the highest-priority unmasked request. At an instruction boundary it freezes the program counter, pushes the current PC onto the return stack, and redirects the counter to a per-line vector address. It sits between the external request lines and the processor's counter and stack controls. Its jump/push outputs are OR-ed with the instruction decoder's controls at processor level.

## Interface
- NUM_IRQ, 4, number of request lines (1..8)
- WIDTH, 16, PC / address width
- VEC_BASE, 16'h0008, vector address of line 0
- VEC_STRIDE, 4, address distance between consecutive vectors
- clk  in  1  processor clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- irq  in  NUM_IRQ  request lines, rising-edge sensitive, synchronous to clk
- irq_mask  in  NUM_IRQ  1 = line masked (still latches, never dispatched)
- ien  in  1  global interrupt enable
- boundary  in  1  core is between instructions; redirect allowed this cycle
- stack_full  in  1  return stack full flag
- pc  in  WIDTH  current program counter value
- reti  in  1  one-cycle pulse from decoder: return-from-interrupt executed
- hold  out  1  freeze program counter
- stack_push  out  1  push pc onto return stack
- jmp_en  out  1  load counter with jmp_addr
- jmp_addr  out  WIDTH  vector address; 0 when jmp_en = 0
- irq_ack  out  NUM_IRQ  one-hot acknowledge pulse for the dispatched line
- active  out  1  handler in progress
- pending  out  NUM_IRQ  latched request bits
- lost  out  1  sticky: edge arrived on a line whose pending bit was already set

## Operation
- Edge detect: prev register samples irq every cycle. On reset, prev loads the current irq value, so a line held high through reset produces no pending bit.
- Pending: pending[i] is set on an irq[i] rising edge. It is cleared in the JUMP cycle for the dispatched line. If a new edge on the same line coincides with the clear, the set wins. An edge on an already-set bit sets lost.
- Eligible = pending & ~irq_mask, considered only when ien = 1. Priority goes to the lowest index.
- Vector = VEC_BASE + idx*VEC_STRIDE, truncated to WIDTH bits (wraps).
- FSM states: IDLE, PUSH, JUMP, SERVICE.
  - IDLE → PUSH when eligible != 0, boundary = 1 and stack_full = 0. The winning index is registered on this transition. If stack_full = 1, stay in IDLE with pending held.
  - PUSH (1 cycle): hold = 1 and stack_push = 1. The stack captures pc, which is the address of the last completed instruction. → JUMP.
  - JUMP (1 cycle): jmp_en = 1, jmp_addr = vector, irq_ack[idx] = 1, pending[idx] cleared. → SERVICE.
  - SERVICE: active = 1, no nesting, and pending keeps latching. reti = 1 → IDLE. The core pops the stack and resumes at pc+1.
- reti outside SERVICE is ignored.
- Masking or clearing ien after IDLE → PUSH does not abort the sequence.
- Reset (any state): state = IDLE; pending, lost, and all outputs = 0.

## Timing
- Edge sampled at clock edge k → pending visible from cycle k+1.
- Best case, with eligible, boundary and !stack_full in cycle k+1: PUSH in cycle k+2, JUMP in k+3, active from k+4.
- Latency from pending visible to jmp_en is 2 cycles.
- hold, stack_push, jmp_en and irq_ack are each asserted for exactly one cycle per dispatch.
- reti seen in cycle m → active = 0 in cycle m+1. A re-dispatch can start in m+1 (PUSH in m+2).
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Test plan
- Single request, ien = 1, boundary = 1, pc = 0x0005: pulse irq[2] → stack_push with pc = 0x0005; next cycle jmp_en = 1, jmp_addr = 0x0010, irq_ack = 4'b0100, pending = 0; then reti → active drops 1 cycle later.
- Priority: edges on irq[3] and irq[1] in the same cycle → line 1 is dispatched (jmp_addr = 0x000C). After reti, line 3 is dispatched (jmp_addr = 0x0014) with no new edge.
- Blocking: pending set with mask = 1, or ien = 0, or boundary = 0, or stack_full = 1 → no hold/push/jump. Removing the blocker dispatches within 2 cycles.
- Boundaries: irq[0] held high through reset → pending = 0. A second edge on irq[0] while pending[0] = 1 → lost = 1. An edge on irq[0] in its own JUMP cycle → pending[0] stays 1.
- Reset mid-sequence: assert rst in the PUSH cycle and again in SERVICE → next cycle IDLE, all outputs 0, pending = 0.
- Vector wrap: WIDTH = 16, VEC_BASE = 16'hFFFC, VEC_STRIDE = 4 → line 1 vector = 0x0000.
